// File: rtl/aes_ks_pkg.sv
// Shared definitions for the AES key-expansion engine: key length encodings,
// Nk/Nr lookup, round constants and FSM state encoding.
package aes_ks_pkg;

    localparam logic [1:0] KEY_LEN_128 = 2'd0;
    localparam logic [1:0] KEY_LEN_192 = 2'd1;
    localparam logic [1:0] KEY_LEN_256 = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_FLUSH  = 2'd2
    } ks_state_t;

    // Zero flags an illegal encoding.
    function automatic logic [3:0] nk_of(input logic [1:0] key_len);
        case (key_len)
            KEY_LEN_128: return 4'd4;
            KEY_LEN_192: return 4'd6;
            KEY_LEN_256: return 4'd8;
            default:     return 4'd0;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] key_len);
        case (key_len)
            KEY_LEN_128: return 4'd10;
            KEY_LEN_192: return 4'd12;
            KEY_LEN_256: return 4'd14;
            default:     return 4'd0;
        endcase
    endfunction

    function automatic logic [7:0] rcon_of(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/aes_key_schedule_sbox.sv
// Combinational AES S-box for one byte: GF(2^8) inverse (x^254) followed by
// the FIPS-197 affine transform. Zero latency, no flow control.
module aes_sbox_byte (
    input  logic [7:0] a,
    output logic [7:0] y
);

    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
        logic [7:0] p;
        logic [7:0] xx;
        p  = 8'h00;
        xx = x;
        for (int b = 0; b < 8; b++) begin
            if (z[b]) p = p ^ xx;
            xx = {xx[6:0], 1'b0} ^ (xx[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] inv;
    logic [7:0] sq;

    // x^254 = product of x^(2^k) for k = 1..7; maps 0 to 0 as the S-box needs.
    always_comb begin
        inv = 8'h01;
        sq  = a;
        for (int k = 1; k < 8; k++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

endmodule

// File: rtl/aes_key_schedule.sv
// AES-128/192/256 key expansion, one schedule word per cycle, 128-bit round keys on a valid/ready stream.
// Latency: round key r valid 4r+4 cycles after start; AES_KS_STORE_EN adds a 15-entry read-back store.
// Backpressure: rk_valid && !rk_ready freezes the word generator; rk_data/rk_index hold until accepted.
module aes_key_schedule
    import aes_ks_pkg::*;
#(
    parameter int MAX_NK = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [255:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         key_err,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_index,
    input  logic [3:0]   rd_addr,
    output logic [127:0] rd_data
);

    localparam int AW = (MAX_NK > 4) ? 3 : 2;

    ks_state_t      state;
    logic [31:0]    win [MAX_NK];
    logic [31:0]    key_word [8];
    logic [3:0]     nk, nr, rcnt, start_nk;
    logic [5:0]     i;
    logic [2:0]     j;
    logic [AW-1:0]  old_idx;
    logic [31:0]    w_prev, w_old, sb_in, sb_out, t, w_new;
    logic [127:0]   new_rk;
    logic           keyphase, advance, load, accept, start_ok, start_go;

    for (genvar g = 0; g < 8; g++) begin : g_kw
        assign key_word[g] = key_in[255-32*g -: 32];
    end

    assign start_nk = nk_of(key_len);
    assign start_ok = (start_nk != 4'd0) && (start_nk <= 4'(MAX_NK));
    assign start_go = (state == ST_IDLE) && start && !done && start_ok;

    assign old_idx  = AW'(nk - 4'd1);
    assign w_prev   = win[0];
    assign w_old    = win[old_idx];
    assign keyphase = (i < {2'b00, nk});
    assign advance  = (state == ST_EXPAND) && !(rk_valid && !rk_ready);
    assign load     = advance && (i[1:0] == 2'b11);
    assign accept   = rk_valid && rk_ready;
    assign sb_in    = (j == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    assign new_rk   = {win[2], win[1], win[0], w_new};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox_byte u_sbox (.a(sb_in[8*g +: 8]), .y(sb_out[8*g +: 8]));
    end

    // During the first Nk words the window is a rotating copy of the key.
    always_comb begin
        t = w_prev;
        if (j == 3'd0)
            t = sb_out ^ {rcon_of(rcnt), 24'h0};
        else if (nk == 4'd8 && j == 3'd4)
            t = sb_out;
        w_new = keyphase ? w_old : (w_old ^ t);
    end

    // Key loaded oldest-first at win[nk-1] so the key phase is a pure rotation.
    always_ff @(posedge clk) begin
        if (start_go) begin
            for (int k = 0; k < MAX_NK; k++)
                win[k] <= (k < int'(start_nk)) ? key_word[3'(int'(start_nk) - 1 - k)] : 32'h0;
        end else if (advance) begin
            win[0] <= w_new;
            for (int k = 1; k < MAX_NK; k++)
                win[k] <= win[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            key_err  <= 1'b0;
            rk_valid <= 1'b0;
            rk_data  <= '0;
            rk_index <= '0;
            i        <= '0;
            j        <= '0;
            rcnt     <= 4'd1;
            nk       <= '0;
            nr       <= '0;
        end else begin
            done    <= 1'b0;
            key_err <= 1'b0;
            if (accept) rk_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_go) begin
                        state <= ST_EXPAND;
                        busy  <= 1'b1;
                        nk    <= start_nk;
                        nr    <= nr_of(key_len);
                        i     <= '0;
                        j     <= '0;
                        rcnt  <= 4'd1;
                    end else if (start && !done && !start_ok) begin
                        key_err <= 1'b1;
                    end
                end
                ST_EXPAND: begin
                    if (advance) begin
                        i <= i + 6'd1;
                        j <= ({1'b0, j} == nk - 4'd1) ? 3'd0 : j + 3'd1;
                        if (!keyphase && j == 3'd0) rcnt <= rcnt + 4'd1;
                        if (load) begin
                            rk_valid <= 1'b1;
                            rk_data  <= new_rk;
                            rk_index <= i[5:2];
                        end
                        if (i == {nr, 2'b11}) state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (accept) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef AES_KS_STORE_EN
    logic [127:0] mem [15];

    always_ff @(posedge clk) begin
        if (load) mem[i[5:2]] <= new_rk;
    end

    always_ff @(posedge clk) begin
        if (rst)
            rd_data <= '0;
        else if (load && i[5:2] == rd_addr)
            rd_data <= new_rk;
        else if (rd_addr <= 4'd14)
            rd_data <= mem[rd_addr];
        else
            rd_data <= '0;
    end
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^rd_addr;
    assign rd_data        = '0;
`endif

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule: FIPS-197 vectors for all key lengths,
// backpressure, illegal key length, start while busy, mid-run reset, read-back store.
module tb_aes_key_schedule;

    logic         clk = 1'b0;
    logic         rst, start, rk_ready;
    logic [1:0]   key_len;
    logic [255:0] key_in;
    logic         busy, done, key_err, rk_valid;
    logic [127:0] rk_data, rd_data;
    logic [3:0]   rk_index, rd_addr;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic [127:0] got_keys [15];
    int           got_n, got_first, got_last, got_done, inject_c;
    bit           got_order_ok, got_stable_ok, got_err_seen, got_busy_at_done;
    logic [255:0] inject_key;

    aes_key_schedule dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_len  (key_len),
        .key_in   (key_in),
        .busy     (busy),
        .done     (done),
        .key_err  (key_err),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_data  (rk_data),
        .rk_index (rk_index),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    always #5 clk = ~clk;

    // Drives one expansion and records what the stream presented; cycle c counts edges after start was sampled.
    task automatic run_expand(input logic [1:0] len, input logic [255:0] key, input bit rnd);
        logic         pv, pr;
        logic [127:0] pd;
        logic [3:0]   pi;
        got_n = 0; got_first = -1; got_last = -1; got_done = -1;
        got_order_ok = 1; got_stable_ok = 1; got_err_seen = 0; got_busy_at_done = 1;
        @(negedge clk);
        key_len = len; key_in = key; start = 1'b1; rk_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        pv = 1'b0; pr = rk_ready; pd = '0; pi = '0;
        for (int c = 1; c < 3000; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (key_err) got_err_seen = 1;
            if (pv && !pr) begin
                if (!(rk_valid && rk_data === pd && rk_index === pi)) got_stable_ok = 0;
            end else if (rk_valid) begin
                if (got_n > 14 || rk_index !== 4'(got_n)) got_order_ok = 0;
                if (got_n < 15) got_keys[got_n] = rk_data;
                if (got_first < 0) got_first = c;
                got_last = c;
                got_n++;
            end
            if (done) begin
                got_done = c;
                got_busy_at_done = busy;
                break;
            end
            if (c == inject_c) begin
                start = 1'b1; key_len = 2'd2; key_in = inject_key;
            end
            rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            pv = rk_valid; pr = rk_ready; pd = rk_data; pi = rk_index;
        end
        start = 1'b0;
        rk_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; rk_ready = 1'b1; key_len = '0; key_in = '0; rd_addr = '0;
        inject_c = -1; inject_key = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0)     begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (key_err !== 1'b0)  begin n_fail++; $display("FAIL reset_key_err got %b want 0", key_err); end
        n_checks++; if (rk_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rk_valid got %b want 0", rk_valid); end
        n_checks++; if (rk_data !== '0)    begin n_fail++; $display("FAIL reset_rk_data got %h want 0", rk_data); end
        n_checks++; if (rk_index !== '0)   begin n_fail++; $display("FAIL reset_rk_index got %0d want 0", rk_index); end
        n_checks++; if (rd_data !== '0)    begin n_fail++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
    endtask

    task automatic test_aes128();
        run_expand(2'd0, K128, 1'b0);
        n_checks++; if (got_n != 11)       begin n_fail++; $display("FAIL aes128_count got %0d want 11", got_n); end
        n_checks++; if (got_first != 4)    begin n_fail++; $display("FAIL aes128_rk0_latency got %0d want 4", got_first); end
        n_checks++; if (got_last != 44)    begin n_fail++; $display("FAIL aes128_last_latency got %0d want 44", got_last); end
        n_checks++; if (got_done != 45)    begin n_fail++; $display("FAIL aes128_done_cycle got %0d want 45", got_done); end
        n_checks++; if (got_busy_at_done)  begin n_fail++; $display("FAIL aes128_busy_at_done got 1 want 0"); end
        n_checks++; if (!got_order_ok)     begin n_fail++; $display("FAIL aes128_order got 0 want 1"); end
        n_checks++; if (got_keys[0] !== 128'h2b7e151628aed2a6abf7158809cf4f3c)
            begin n_fail++; $display("FAIL aes128_rk0 got %h want 2b7e151628aed2a6abf7158809cf4f3c", got_keys[0]); end
        n_checks++; if (got_keys[1] !== 128'ha0fafe1788542cb123a339392a6c7605)
            begin n_fail++; $display("FAIL aes128_rk1 got %h want a0fafe1788542cb123a339392a6c7605", got_keys[1]); end
        n_checks++; if (got_keys[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6)
            begin n_fail++; $display("FAIL aes128_rk10 got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", got_keys[10]); end
    endtask

    task automatic test_store();
        logic [127:0] exp_rd;
`ifdef AES_KS_STORE_EN
        exp_rd = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
`else
        exp_rd = 128'h0;
`endif
        @(negedge clk);
        rd_addr = 4'd10;
        @(negedge clk);
        n_checks++; if (rd_data !== exp_rd) begin n_fail++; $display("FAIL store_rd10 got %h want %h", rd_data, exp_rd); end
        rd_addr = 4'd0;
    endtask

    task automatic test_aes192();
        run_expand(2'd1, K192, 1'b0);
        n_checks++; if (got_n != 13)    begin n_fail++; $display("FAIL aes192_count got %0d want 13", got_n); end
        n_checks++; if (got_done != 53) begin n_fail++; $display("FAIL aes192_done_cycle got %0d want 53", got_done); end
        n_checks++; if (got_keys[0] !== 128'h8e73b0f7da0e6452c810f32b809079e5)
            begin n_fail++; $display("FAIL aes192_rk0 got %h want 8e73b0f7da0e6452c810f32b809079e5", got_keys[0]); end
        n_checks++; if (got_keys[1] !== 128'h62f8ead2522c6b7bfe0c91f72402f5a5)
            begin n_fail++; $display("FAIL aes192_rk1 got %h want 62f8ead2522c6b7bfe0c91f72402f5a5", got_keys[1]); end
        n_checks++; if (got_keys[12] !== 128'he98ba06f448c773c8ecc720401002202)
            begin n_fail++; $display("FAIL aes192_rk12 got %h want e98ba06f448c773c8ecc720401002202", got_keys[12]); end
    endtask

    task automatic test_aes256();
        run_expand(2'd2, K256, 1'b0);
        n_checks++; if (got_n != 15)    begin n_fail++; $display("FAIL aes256_count got %0d want 15", got_n); end
        n_checks++; if (got_done != 61) begin n_fail++; $display("FAIL aes256_done_cycle got %0d want 61", got_done); end
        n_checks++; if (got_keys[2] !== 128'h9ba354118e6925afa51a8b5f2067fcde)
            begin n_fail++; $display("FAIL aes256_rk2 got %h want 9ba354118e6925afa51a8b5f2067fcde", got_keys[2]); end
        n_checks++; if (got_keys[14] !== 128'hfe4890d1e6188d0b046df344706c631e)
            begin n_fail++; $display("FAIL aes256_rk14 got %h want fe4890d1e6188d0b046df344706c631e", got_keys[14]); end
    endtask

    task automatic test_backpressure();
        run_expand(2'd2, K256, 1'b1);
        n_checks++; if (got_n != 15)    begin n_fail++; $display("FAIL bp_count got %0d want 15", got_n); end
        n_checks++; if (got_done < 61)  begin n_fail++; $display("FAIL bp_done_cycle got %0d want >=61", got_done); end
        n_checks++; if (!got_order_ok)  begin n_fail++; $display("FAIL bp_order got 0 want 1"); end
        n_checks++; if (!got_stable_ok) begin n_fail++; $display("FAIL bp_stable got 0 want 1"); end
        n_checks++; if (got_keys[1] !== 128'h1f352c073b6108d72d9810a30914dff4)
            begin n_fail++; $display("FAIL bp_rk1 got %h want 1f352c073b6108d72d9810a30914dff4", got_keys[1]); end
        n_checks++; if (got_keys[2] !== 128'h9ba354118e6925afa51a8b5f2067fcde)
            begin n_fail++; $display("FAIL bp_rk2 got %h want 9ba354118e6925afa51a8b5f2067fcde", got_keys[2]); end
        n_checks++; if (got_keys[14] !== 128'hfe4890d1e6188d0b046df344706c631e)
            begin n_fail++; $display("FAIL bp_rk14 got %h want fe4890d1e6188d0b046df344706c631e", got_keys[14]); end
    endtask

    task automatic test_key_err();
        @(negedge clk);
        key_len = 2'd3; key_in = K128; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++; if (key_err !== 1'b1) begin n_fail++; $display("FAIL key_err_pulse got %b want 1", key_err); end
        n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL key_err_busy got %b want 0", busy); end
        @(negedge clk);
        n_checks++; if (key_err !== 1'b0) begin n_fail++; $display("FAIL key_err_one_cycle got %b want 0", key_err); end
        n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL key_err_idle got %b want 0", busy); end
    endtask

    task automatic test_start_while_busy();
        inject_c = 10; inject_key = K256;
        run_expand(2'd0, K128, 1'b0);
        inject_c = -1;
        n_checks++; if (got_n != 11)    begin n_fail++; $display("FAIL busy_start_count got %0d want 11", got_n); end
        n_checks++; if (got_done != 45) begin n_fail++; $display("FAIL busy_start_done got %0d want 45", got_done); end
        n_checks++; if (got_err_seen)   begin n_fail++; $display("FAIL busy_start_key_err got 1 want 0"); end
        n_checks++; if (got_keys[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6)
            begin n_fail++; $display("FAIL busy_start_rk10 got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", got_keys[10]); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        key_len = 2'd0; key_in = K128; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL mid_rst_busy got %b want 0", busy); end
        n_checks++; if (rk_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_rk_valid got %b want 0", rk_valid); end
        n_checks++; if (rk_data !== '0)    begin n_fail++; $display("FAIL mid_rst_rk_data got %h want 0", rk_data); end
        n_checks++; if (rk_index !== '0)   begin n_fail++; $display("FAIL mid_rst_rk_index got %0d want 0", rk_index); end
        n_checks++; if (done !== 1'b0)     begin n_fail++; $display("FAIL mid_rst_done got %b want 0", done); end
        rst = 1'b0;
        run_expand(2'd0, K128, 1'b0);
        n_checks++; if (got_done != 45) begin n_fail++; $display("FAIL mid_rst_rerun_done got %0d want 45", got_done); end
        n_checks++; if (got_keys[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6)
            begin n_fail++; $display("FAIL mid_rst_rerun_rk10 got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", got_keys[10]); end
    endtask

    initial begin
        test_reset();
        test_aes128();
        test_store();
        test_aes192();
        test_aes256();
        test_backpressure();
        test_key_err();
        test_start_while_busy();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_key_schedule.md
Name: aes_key_schedule

Overview:
- Sequential, parametrised AES key-expansion engine supporting AES-128, AES-192 and AES-256 (Nk = 4/6/8, Nr = 10/12/14).
- Generates one 32-bit schedule word per cycle. Packs each four words into a 128-bit round key and hands it out over a valid/ready stream, so it replaces the fixed 128-bit combinational round-expansion path.
- Sits between the key register interface and the AES_CTR round pipeline. It can optionally retain the whole schedule for random-access reads.

Parameters:
- MAX_NK, 8, largest key length supported in words. Legal values: 4, 6, 8. Synthesises only the window and control needed for it.

Ports:
- clk  in  1  sole clock. Everything is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to expand key_in. Ignored while busy=1.
- key_len  in  2  0=128, 1=192, 2=256. 3 is illegal.
- key_in  in  256  FIPS-197 word order: w0=key_in[255:224], w1=[223:192], … Unused low words are ignored (AES-128 uses [255:128]).
- busy  out  1  expansion in progress.
- done  out  1  one-cycle pulse when the last round key is accepted.
- key_err  out  1  one-cycle pulse on start with key_len=3, or with Nk>MAX_NK.
- rk_valid  out  1  round key present on rk_data.
- rk_ready  in  1  consumer accepts the key when rk_valid&&rk_ready.
- rk_data  out  128  round key; [127:96] = w[4r].
- rk_index  out  4  round number r, 0..Nr.
- rd_addr  in  4  schedule read address (optional feature).
- rd_data  out  128  schedule read data (optional feature).

Behaviour:
- Reset values: busy=0, done=0, key_err=0, rk_valid=0, rk_data=0, rk_index=0, rd_data=0. FSM goes to IDLE and the word counter is cleared.
- rst mid-expansion aborts immediately. No done is produced, and the stored schedule is undefined until the next full run.
- FSM states: IDLE, EXPAND, FLUSH.
  - IDLE → EXPAND: on start with a legal key_len. Latch Nk/Nr and key words, set busy, clear word index i.
  - Illegal start: pulse key_err and stay in IDLE.
  - start while busy: ignored, with no error.
- EXPAND, word generation:
  - i advances by 1 per cycle unless stalled (rk_valid && !rk_ready).
  - For i < Nk: w[i] = key word i.
  - Otherwise: w[i] = w[i-Nk] ^ t, where t = w[i-1], except:
    - i mod Nk == 0: t = SubWord(RotWord(w[i-1])) ^ {Rcon[i/Nk], 24'h0}.
    - Nk == 8 and i mod Nk == 4: t = SubWord(w[i-1]).
  - Sliding window: MAX_NK x 32-bit shift register.
- Packing:
  - Words accumulate into a 4-word group.
  - When word 4r+3 is registered, the group is loaded into rk_data, rk_index=r, and rk_valid=1.
  - rk_valid clears on handshake unless a new group loads in the same cycle.
- Latency: with rk_ready held at 1, start is sampled at edge T0 and round key r is valid after edge T0+4r+4. Hence rk0 at +4 and the last key at +4(Nr+1) (AES-128: +44).
- Backpressure:
  - The generator holds i and the window while rk_valid && !rk_ready.
  - rk_data and rk_index are stable while rk_valid=1 and not accepted.
- Ending a run:
  - After word 4(Nr+1)-1 is generated, go to FLUSH.
  - On acceptance of r=Nr: pulse done, clear busy, return to IDLE.
  - A start in the same cycle as done is ignored.
- Total words generated: 44/52/60. Rcon index max is 10/8/7.

Optional Feature:
- AES_KS_STORE_EN defined:
  - A 15x128 register file is written with each round key at index r when the key loads into rk_data.
  - rd_data = mem[rd_addr], registered with 1-cycle latency.
  - Addresses above Nr of the last run return stale or zero data.
  - A read of an address written in the same cycle returns the new value.
- AES_KS_STORE_EN undefined: no storage; rd_data is tied to 0 and rd_addr is unused.

Decomposition:
- Package aes_ks_pkg holds:
  - key_len encodings and the Nk/Nr lookup per encoding.
  - RCON[1:10] = 01,02,04,08,10,20,40,80,1B,36.
  - State encoding for IDLE/EXPAND/FLUSH.
- Sub-module aes_sbox_byte: combinational 8-bit S-box, instantiated 4x for SubWord.

Test Plan:
- AES-128 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 → rk0=key, rk1=a0fafe1788542cb123a339392a6c7605, rk10=d014f9a8c9ee2589e13f0cc8b6630ca6 valid at T0+44; done at T0+45.
- AES-192 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → 13 keys; rk12=e98ba06f448c773c8ecc720401002202.
- AES-256 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → 15 keys; rk14=fe4890d1e6188d0b046df344706c631e.
- Random rk_ready toggling on AES-256 → identical key sequence; rk_data/rk_index stable while stalled; no round skipped or duplicated.
- Edge cases:
  - key_len=3 → key_err pulse, busy stays 0.
  - Second start during busy → ignored.
  - rst asserted at i=20 → all outputs 0 next cycle; a new start then completes correctly.
- With AES_KS_STORE_EN, after the AES-128 run: rd_addr=10 → rd_data=d014f9a8c9ee2589e13f0cc8b6630ca6 one cycle later. Without the macro, rd_data=0.
